copro_result_queue: RTL
=======================

Name: copro_result_queue

Overview:
- Sits between the coprocessor ALU result registers and the CVXIF result channel toward the core.
- The ALU emits one-cycle result pulses with no back-pressure. This block buffers them in a DEPTH-entry FIFO and presents them to the core with a valid/ready handshake.
- It also throttles instruction issue with a credit scheme, so a result can never arrive while the FIFO has no room.

Parameters:
- XLEN, 32, result data width.
- HartIdWidth, 1, width of hartid fields.
- IdWidth, 4, width of instruction id fields.
- DEPTH, 4, FIFO entries; power of two, >=2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush of queue and credits.
- issue_accept_i  in  1  pulse: one instruction handed to the ALU this cycle.
- issue_ready_o  out  1  a slot is free for a new issue.
- alu_valid_i  in  1  ALU result valid (single-cycle pulse).
- alu_result_i  in  XLEN  ALU result data.
- alu_hartid_i  in  HartIdWidth  ALU hartid.
- alu_id_i  in  IdWidth  ALU instruction id.
- alu_rd_i  in  5  destination register.
- alu_we_i  in  1  register write enable.
- result_valid_o  out  1  CVXIF result valid.
- result_ready_i  in  1  CVXIF result ready from core.
- result_data_o  out  XLEN  head entry data.
- result_hartid_o  out  HartIdWidth  head entry hartid.
- result_id_o  out  IdWidth  head entry id.
- result_rd_o  out  5  head entry rd.
- result_we_o  out  1  head entry we.
- count_o  out  $clog2(DEPTH)+1  occupied entries.
- overflow_o  out  1  sticky error: push attempted while full.

Behaviour:
- Storage:
  - Circular FIFO of {data, hartid, id, rd, we}.
  - Write pointer, read pointer and count are registers.
  - Pointers wrap modulo DEPTH.
- Push:
  - alu_valid_i=1 pushes at the rising edge.
  - Entries with we=0 (NOP results) are still pushed; every issued instruction needs exactly one result.
- Pop:
  - A pop occurs when result_valid_o && result_ready_i at the edge.
  - result_valid_o = (count != 0).
  - result_*_o are driven combinationally from the head entry.
- Latency: a result pulsed in cycle N is visible on result_valid_o in cycle N+1 (no bypass). Minimum occupancy time is one cycle.
- Handshake:
  - Once result_valid_o=1, the head fields stay stable until the pop; a later push never alters the head.
  - result_ready_i while empty has no effect.
- Simultaneous push and pop: both happen, count is unchanged, and both pointers advance. This is legal when full (a pop frees the slot in the same edge).
- Push while full with no pop:
  - The entry is dropped; FIFO contents and count are unchanged.
  - overflow_o is set and stays sticky until reset or flush.
- Credits:
  - pending register counts issued instructions whose result has not yet arrived.
  - It increments on issue_accept_i and decrements on alu_valid_i; both in the same cycle leave it unchanged.
  - issue_ready_o = (count + pending) < DEPTH, combinational from registers.
  - issue_accept_i while issue_ready_o=0 is a protocol error: it is ignored and pending is not incremented.
- Flush:
  - flush_i=1 at an edge clears pointers, count, pending and overflow_o. Any push, pop or issue_accept_i in that cycle is discarded.
  - A kill flag set by the flush also discards alu_valid_i in the following cycle, covering the 1-cycle ALU latency. The kill flag then clears.
  - result_valid_o is 0 in the cycle after a flush.
- Reset (asynchronous, rst_ni=0):
  - Pointers, count, pending, overflow and the kill flag are 0; storage is cleared to 0.
  - Outputs during and after reset: result_valid_o=0, all result_*_o=0, count_o=0, overflow_o=0, issue_ready_o=1.
  - Reset mid-operation drops all entries and pending credits with no result emitted.
- Widths: count and pending are $clog2(DEPTH)+1 bits; their sum is compared at one extra bit so no overflow occurs.

Test Plan:
- Single result: issue_accept_i pulse, next cycle alu_valid_i with data=0xDEADBEEF, id=3, rd=5, we=1, ready=1 -> result_valid_o high exactly one cycle, fields match, count returns to 0, pending=0.
- Back-pressure: ready=0, push 4 results (ids 0..3) -> count_o=4, issue_ready_o=0, head id=0 held stable; raise ready -> ids 0,1,2,3 emerge on consecutive cycles.
- Full with simultaneous push/pop: FIFO at 4, ready=1 and alu_valid_i (id=7) in the same cycle -> count stays 4, id=7 appears last, overflow_o=0.
- Overflow: FIFO full, ready=0, force alu_valid_i -> count stays 4, overflow_o=1 sticky, contents unchanged; flush_i -> overflow_o=0, count_o=0.
- Flush kill window: issue, then flush_i in the same cycle the ALU result is still in flight, result pulsing the next cycle -> result discarded, result_valid_o stays 0, pending=0, issue_ready_o=1.
- Async reset mid-stream: 3 entries queued, drop rst_ni between edges -> result_valid_o=0 and count_o=0 immediately; after release issue_ready_o=1 and the queue is empty.

Source files
------------

// File: rtl/copro_result_queue.sv
// Result buffer between the coprocessor ALU and the CVXIF result channel.
// Holds un-back-pressurable ALU results in a circular FIFO and issues credits so it never overflows.
module copro_result_queue #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned HartIdWidth = 1,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       issue_accept_i,
  output logic                       issue_ready_o,
  input  logic                       alu_valid_i,
  input  logic [XLEN-1:0]            alu_result_i,
  input  logic [HartIdWidth-1:0]     alu_hartid_i,
  input  logic [IdWidth-1:0]         alu_id_i,
  input  logic [4:0]                 alu_rd_i,
  input  logic                       alu_we_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [XLEN-1:0]            result_data_o,
  output logic [HartIdWidth-1:0]     result_hartid_o,
  output logic [IdWidth-1:0]         result_id_o,
  output logic [4:0]                 result_rd_o,
  output logic                       result_we_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SumW = CntW + 1;

  typedef struct packed {
    logic [XLEN-1:0]        data;
    logic [HartIdWidth-1:0] hartid;
    logic [IdWidth-1:0]     id;
    logic [4:0]             rd;
    logic                   we;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, pending_q;
  logic            overflow_q, kill_q;

  logic            full, push_req, pop, push, issue_acc, credit_ret;
  logic [SumW-1:0] credit_sum;

  // NOTE: every signal gets a default/value on every path here, so no latch can be inferred.
  always_comb begin
    full          = (count_q == CntW'(DEPTH));
    // Results arriving in the cycle after a flush belong to killed instructions.
    push_req      = alu_valid_i && !kill_q;
    pop           = (count_q != '0) && result_ready_i;
    push          = push_req && (!full || pop);
    credit_sum    = {1'b0, count_q} + {1'b0, pending_q};
    issue_ready_o = (credit_sum < SumW'(DEPTH));
    issue_acc     = issue_accept_i && issue_ready_o;
    // A result with no outstanding credit (protocol error) must not wrap pending below zero.
    credit_ret    = push_req && ((pending_q != '0) || issue_acc);
  end

  // NOTE: storage sits in the async reset so the head fields read 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push && !flush_i) begin
      mem_q[wr_ptr_q] <= '{data: alu_result_i, hartid: alu_hartid_i, id: alu_id_i,
                           rd: alu_rd_i, we: alu_we_i};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      kill_q <= flush_i;
      if (flush_i) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        pending_q  <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        count_q   <= count_q + CntW'(push) - CntW'(pop);
        pending_q <= pending_q + CntW'(issue_acc) - CntW'(credit_ret);
        if (push_req && full && !pop) overflow_q <= 1'b1;
      end
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign result_valid_o  = (count_q != '0);
  assign result_data_o   = head.data;
  assign result_hartid_o = head.hartid;
  assign result_id_o     = head.id;
  assign result_rd_o     = head.rd;
  assign result_we_o     = head.we;
  assign count_o         = count_q;
  assign overflow_o      = overflow_q;

endmodule
